// File: rtl/sfu_pkg.sv
// Shared types and constants for the SFU write-back packer: FSM states, lane
// counts and the requantization helper shared by the datapath.
package sfu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } state_t;

  localparam int LANES_INT8  = 4;
  localparam int LANES_INT16 = 2;

  localparam logic signed [16:0] INT8_MIN = -17'sd128;
  localparam logic signed [16:0] INT8_MAX = 17'sd127;

  // Round-half-up arithmetic right shift; 17 bits hold x + 2^14 without overflow.
  function automatic logic signed [16:0] requant(input logic [15:0] x, input logic [3:0] s);
    logic signed [16:0] xe;
    logic signed [16:0] bias;
    xe   = {x[15], x};
    bias = (s == 4'd0) ? 17'sd0 : (17'sd1 <<< (s - 4'd1));
    return (xe + bias) >>> s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with full/empty flags; a pop frees a slot for a push in the
// same cycle even when full.
module sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/sfu_wb_packer.sv
// SFU write-back stage: requantizes the int16 result stream, packs it into
// 32-bit words and writes them to the scratchpad through a small FIFO.
module sfu_wb_packer
  import sfu_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [3:0]        cfg_shift,
  input  logic              cfg_int8,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  state_t            next_state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  elem_cnt;
  logic [3:0]        shift_q;
  logic              int8_q;
  logic [31:0]       pack_data;
  logic [3:0]        pack_strb;

  logic signed [16:0] y;
  logic [7:0]        elem8;
  logic [15:0]       elem16;
  logic [1:0]        lane;
  logic [1:0]        top_lane;
  logic [31:0]       merged_data;
  logic [3:0]        merged_strb;
  logic              consume;
  logic              is_last;
  logic              word_done;
  logic              drain_done;

  logic              push;
  logic              pop;
  logic [35:0]       fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  // Element datapath: requantize, pick the lane and merge into the pack word.
  always_comb begin
    y = requant(in_data[15:0], shift_q);
    if (y > INT8_MAX)      elem8 = INT8_MAX[7:0];
    else if (y < INT8_MIN) elem8 = INT8_MIN[7:0];
    else                   elem8 = y[7:0];
    elem16   = y[15:0];
    lane     = int8_q ? elem_cnt[1:0] : {1'b0, elem_cnt[0]};
    top_lane = int8_q ? 2'(LANES_INT8 - 1) : 2'(LANES_INT16 - 1);

    merged_data = pack_data;
    merged_strb = pack_strb;
    if (int8_q) begin
      merged_data[{lane, 3'b000} +: 8] = elem8;
      merged_strb[lane]                = 1'b1;
    end else begin
      merged_data[{lane[0], 4'b0000} +: 16] = elem16;
      merged_strb[{lane[0], 1'b0} +: 2]     = 2'b11;
    end

    consume   = (state == COLLECT) && in_valid;
    is_last   = (elem_cnt == len_q);
    word_done = consume && ((lane == top_lane) || is_last);
  end

  assign push       = word_done;
  assign pop        = !fifo_empty && wr_ready;
  // The final pop of this cycle counts as drained.
  assign drain_done = fifo_empty || (pop && fifo_count == CW'(1));

  sync_fifo #(
    .WIDTH(36),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data({merged_strb, merged_data}),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = COLLECT;
      COLLECT: if (consume && is_last) next_state = DRAIN;
      DRAIN:   if (drain_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DRAIN) && drain_done;
    wr_en   = !fifo_empty;
    wr_data = fifo_empty ? 32'd0 : fifo_head[31:0];
    wr_strb = fifo_empty ? 4'd0  : fifo_head[35:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      elem_cnt  <= '0;
      shift_q   <= '0;
      int8_q    <= 1'b0;
      pack_data <= '0;
      pack_strb <= '0;
      overflow  <= 1'b0;
      wr_addr   <= '0;
    end else if (state == IDLE && start) begin
      len_q     <= cfg_len;
      shift_q   <= cfg_shift;
      int8_q    <= cfg_int8;
      elem_cnt  <= '0;
      pack_data <= '0;
      pack_strb <= '0;
      overflow  <= 1'b0;
      wr_addr   <= cfg_base_addr;
    end else begin
      if (consume) begin
        elem_cnt <= elem_cnt + 1'b1;
        if (word_done) begin
          pack_data <= '0;
          pack_strb <= '0;
        end else begin
          pack_data <= merged_data;
          pack_strb <= merged_strb;
        end
      end
      if (push && fifo_full && !pop) overflow <= 1'b1;
      if (pop) wr_addr <= wr_addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_sfu_wb_packer.sv
// Scoreboard bench for sfu_wb_packer: a driver predicts every scratchpad write
// from arithmetic rules, a monitor pops and compares whenever a write is taken.
module tb_sfu_wb_packer;

  localparam int ADDR_W     = 12;
  localparam int FIFO_DEPTH = 4;
  localparam int LEN_W      = 6;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        strb;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic [ADDR_W-1:0] cfg_base_addr = '0;
  logic [3:0]        cfg_shift = '0;
  logic              cfg_int8 = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_valid = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic              wr_ready = 1'b0;
  logic              busy;
  logic              done;
  logic              overflow;

  int  tests = 0;
  int  fails = 0;
  int  done_cnt = 0;
  wr_t exp_q[$];
  int  vals[$];

  sfu_wb_packer #(
    .ADDR_W(ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .cfg_base_addr(cfg_base_addr), .cfg_shift(cfg_shift), .cfg_int8(cfg_int8),
    .in_data(in_data), .in_valid(in_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_ready(wr_ready), .busy(busy),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_wr_en"},    64'(wr_en),    64'd0);
    check_output({tag, "_wr_addr"},  64'(wr_addr),  64'd0);
    check_output({tag, "_wr_data"},  64'(wr_data),  64'd0);
    check_output({tag, "_wr_strb"},  64'(wr_strb),  64'd0);
    check_output({tag, "_busy"},     64'(busy),     64'd0);
    check_output({tag, "_done"},     64'(done),     64'd0);
    check_output({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  // floor(x / 2^s + 1/2) with an optional int8 clamp
  function automatic int ref_requant(input int x, input int s, input bit i8);
    int d, num, q;
    d   = 1 << s;
    num = x + ((s > 0) ? d / 2 : 0);
    q   = num / d;
    if ((num % d) != 0 && num < 0) q = q - 1;
    if (i8) begin
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
    end
    return q;
  endfunction

  function automatic wr_t build_word(input int first, input int last, input int shift,
                                     input bit i8, input logic [ADDR_W-1:0] addr);
    wr_t w;
    int  v;
    w.addr = addr;
    w.data = '0;
    w.strb = '0;
    for (int k = first; k <= last; k++) begin
      v = ref_requant(vals[k], shift, i8);
      if (i8) begin
        w.data = w.data | ((32'(v) & 32'hFF) << (8 * (k - first)));
        w.strb = w.strb | (4'b0001 << (k - first));
      end else begin
        w.data = w.data | ((32'(v) & 32'hFFFF) << (16 * (k - first)));
        w.strb = w.strb | (4'b0011 << (2 * (k - first)));
      end
    end
    return w;
  endfunction

  function automatic bit pick_ready(input int mode, inout bit tog);
    bit r;
    case (mode)
      0:       r = ($urandom_range(0, 3) != 0);
      2:       begin r = tog; tog = !tog; end
      3:       r = 1'b0;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // mode 0: random ready/valid, 1: ready high, 2: ready toggles, 3: ready held low then released
  task automatic apply_stimulus(input int len, input int base, input int shift, input bit i8, input int mode);
    int  lanes, idx, outstanding, kept, done_before;
    bit  exp_ovf, accept, ready, tog, seen_done;
    wr_t w;
    lanes = i8 ? 4 : 2;
    done_before = done_cnt;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = $urandom; wr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; cfg_len = LEN_W'(len); cfg_base_addr = ADDR_W'(base);
    cfg_shift = 4'(shift); cfg_int8 = i8; in_data = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; outstanding = 0; kept = 0; exp_ovf = 0; tog = 0;
    while (idx <= len) begin
      ready    = pick_ready(mode, tog);
      wr_ready = ready;
      in_valid = (mode == 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = {16'($urandom), 16'(vals[idx])};
      start    = ($urandom_range(0, 7) == 0);
      cfg_len = LEN_W'($urandom); cfg_base_addr = ADDR_W'($urandom);
      cfg_shift = 4'($urandom); cfg_int8 = 1'($urandom);
      accept = (outstanding > 0) && ready;
      if (in_valid && ((idx % lanes) == lanes - 1 || idx == len)) begin
        if (outstanding == FIFO_DEPTH && !accept) begin
          exp_ovf = 1'b1;
        end else begin
          w = build_word(idx - (idx % lanes), idx, shift, i8, ADDR_W'(base + kept));
          exp_q.push_back(w);
          kept++;
          outstanding++;
        end
      end
      if (accept) outstanding--;
      if (in_valid) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (mode == 3) begin
      wr_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        check_output("done_while_stalled", 64'(done), 64'd0);
        @(posedge clk); #1;
      end
      @(negedge clk);
      check_output("overflow_while_stalled", 64'(overflow), 64'(exp_ovf));
      @(posedge clk); #1;
    end
    seen_done = 1'b0;
    for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
      wr_ready = (mode == 3) ? 1'b1 : pick_ready(mode, tog);
      start    = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      if (done) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_output("done_seen", 64'(seen_done), 64'd1);
    check_output("writes_pending_at_done", 64'(exp_q.size()), 64'd0);
    check_output("overflow_final", 64'(overflow), 64'(exp_ovf));
    check_output("busy_after_done", 64'(busy), 64'd0);
    check_output("done_one_cycle", 64'(done), 64'd0);
    check_output("done_pulse_count", 64'(done_cnt - done_before), 64'd1);
    exp_q.delete();
  endtask

  task automatic reset_abort();
    @(posedge clk); #1;
    start = 1'b1; cfg_len = 6'd5; cfg_base_addr = 12'h0AB; cfg_shift = 4'd0;
    cfg_int8 = 1'b1; in_valid = 1'b0; wr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'h0000_0077;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_output("abort_busy_before_reset", 64'(busy), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: compare every accepted write and hold-stability during stalls.
  initial begin : monitor
    wr_t        w;
    logic       stall_prev;
    logic [48:0] prev;
    stall_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (stall_prev)
        check_output("stall_stable", 64'({wr_en, wr_addr, wr_data, wr_strb}), 64'(prev));
      if (wr_en && wr_ready && !rst) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
        end else begin
          w = exp_q.pop_front();
          check_output("wr_addr", 64'(wr_addr), 64'(w.addr));
          check_output("wr_data", 64'(wr_data), 64'(w.data));
          check_output("wr_strb", 64'(wr_strb), 64'(w.strb));
        end
      end
      stall_prev = wr_en && !wr_ready && !rst;
      prev = {wr_en, wr_addr, wr_data, wr_strb};
    end
  end

  initial begin
    int len;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    vals = '{6, -6, 5, -5};
    apply_stimulus(3, 12'h040, 2, 1'b1, 1);
    vals = '{1000, -1000, 127, -128};
    apply_stimulus(3, 12'h080, 0, 1'b1, 1);
    vals = '{1, 2, 3, 4, 5};
    apply_stimulus(4, 12'h010, 0, 1'b1, 1);

    vals.delete();
    for (int i = 0; i < 16; i++) vals.push_back(int'($urandom_range(0, 65535)) - 32768);
    apply_stimulus(15, 12'h200, 1, 1'b0, 3);

    vals.delete();
    for (int i = 0; i < 8; i++) vals.push_back(int'($urandom_range(0, 65535)) - 32768);
    apply_stimulus(7, 12'h300, 3, 1'b0, 2);

    reset_abort();
    vals = '{-3};
    apply_stimulus(0, 12'h123, 0, 1'b1, 1);
    vals = '{32767, -32768, 300};
    apply_stimulus(2, 12'h124, 0, 1'b0, 1);

    for (int t = 0; t < 12; t++) begin
      len = $urandom_range(0, 40);
      vals.delete();
      for (int i = 0; i <= len; i++) vals.push_back(int'($urandom_range(0, 65535)) - 32768);
      apply_stimulus(len, (t % 3 == 0) ? 12'hFFE : int'($urandom_range(0, 4095)),
                     $urandom_range(0, 15), 1'($urandom), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
